// File: rtl/doodle_pkg.sv
// Shared screen geometry and one-hot game-state encodings used by the doodle
// state machine and the motion datapath.
package doodle_pkg;

  localparam int unsigned H_OFFSET      = 144;
  localparam int unsigned V_TOP         = 35;
  localparam int unsigned V_BOTTOM      = 515;
  localparam int unsigned V_MIDDLE      = 275;
  localparam int unsigned DOODLE_RADIUS = 10;

  // Bit order is {q_I, q_Up, q_Down, q_Done}.
  typedef enum logic [3:0] {
    ST_I    = 4'b1000,
    ST_UP   = 4'b0100,
    ST_DOWN = 4'b0010,
    ST_DONE = 4'b0001
  } doodle_state_e;

  function automatic logic is_one_hot4(input logic [3:0] v);
    return (v != 4'b0000) && ((v & (v - 4'b0001)) == 4'b0000);
  endfunction

endpackage

// File: rtl/doodle_tick_gen.sv
// Motion-step divider: counts 0..TICK_DIV-1 while enabled and flags the last
// count; restart clears it, and with neither asserted the count is held.
module doodle_tick_gen
  import doodle_pkg::*;
#(
  parameter int unsigned TICK_DIV = 500000
) (
  input  logic Clk,
  input  logic Reset,
  input  logic enable,
  input  logic restart,
  output logic tick
);

  localparam int unsigned CNT_W = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_cnt <= '0;
    end else if (restart) begin
      r_cnt <= '0;
    end else if (enable) begin
      r_cnt <= (r_cnt == CNT_MAX) ? '0 : r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign tick = enable && !restart && (r_cnt == CNT_MAX);

endmodule

// File: rtl/doodle_motion.sv
// Doodle position datapath: steps the sprite vertically with the jump phase and
// horizontally with the player buttons, wrapping at the playfield edges.
module doodle_motion
  import doodle_pkg::*;
#(
  parameter int unsigned TICK_DIV    = 500000,
  parameter logic [7:0]  JUMP_HEIGHT = 8'd120,
  parameter int unsigned STEP_X      = 2,
  parameter int unsigned X_START     = 459,
  parameter int unsigned Y_START     = 455,
  parameter int unsigned X_MIN       = 154,
  parameter int unsigned X_MAX       = 764,
  parameter int unsigned Y_TOP       = 35,
  parameter int unsigned Y_FLOOR     = 520
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       q_I,
  input  logic       q_Up,
  input  logic       q_Down,
  input  logic       q_Done,
  input  logic       is_in_middle,
  input  logic       BtnL,
  input  logic       BtnR,
  output logic [9:0] object_x,
  output logic [9:0] object_y,
  output logic [7:0] up_count,
  output logic       move_tick
);

  localparam logic [9:0]  X_START_V = 10'(X_START);
  localparam logic [9:0]  Y_START_V = 10'(Y_START);
  localparam logic [9:0]  X_MIN_V   = 10'(X_MIN);
  localparam logic [9:0]  X_MAX_V   = 10'(X_MAX);
  localparam logic [9:0]  Y_TOP_V   = 10'(Y_TOP);
  localparam logic [9:0]  Y_FLOOR_V = 10'(Y_FLOOR);
  localparam logic [10:0] STEP_W    = 11'(STEP_X);

  logic [9:0]  r_x, r_y;
  logic [7:0]  r_up;
  logic [1:0]  r_edge;
  logic [1:0]  r_btn_l, r_btn_r;
  logic [3:0]  w_state;
  logic        w_valid, w_first_up, w_first_down;
  logic        w_enable, w_restart, w_tick;
  logic        w_left, w_right;
  logic [10:0] w_x_ext, w_x_left, w_x_right;
  logic [9:0]  w_x_step, w_x_nxt, w_y_nxt;
  logic [7:0]  w_up_nxt;

  assign w_state      = {q_I, q_Up, q_Down, q_Done};
  assign w_valid      = is_one_hot4(w_state);
  assign w_first_up   = q_Up & ~r_edge[1];
  assign w_first_down = q_Down & ~r_edge[0];
  assign w_enable     = w_valid & (q_Up | q_Down);
  assign w_restart    = w_valid & (q_I | q_Done | w_first_up | w_first_down);

  doodle_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
    .Clk    (Clk),
    .Reset  (Reset),
    .enable (w_enable),
    .restart(w_restart),
    .tick   (w_tick)
  );

  assign w_left    = r_btn_l[1] & ~r_btn_r[1];
  assign w_right   = r_btn_r[1] & ~r_btn_l[1];
  assign w_x_ext   = {1'b0, r_x};
  assign w_x_left  = w_x_ext - STEP_W;
  assign w_x_right = w_x_ext + STEP_W;

  // Edge-wrapping horizontal step; the left bound is compared before subtracting.
  always_comb begin
    w_x_step = r_x;
    if (w_left) begin
      w_x_step = (w_x_ext < ({1'b0, X_MIN_V} + STEP_W)) ? X_MAX_V : w_x_left[9:0];
    end else if (w_right) begin
      w_x_step = (w_x_right > {1'b0, X_MAX_V}) ? X_MIN_V : w_x_right[9:0];
    end else begin
      w_x_step = r_x;
    end
  end

  always_comb begin
    w_x_nxt  = r_x;
    w_y_nxt  = r_y;
    w_up_nxt = r_up;
    if (w_valid) begin
      case (w_state)
        ST_I: begin
          w_x_nxt  = X_START_V;
          w_y_nxt  = Y_START_V;
          w_up_nxt = 8'd0;
        end
        ST_UP: begin
          if (w_first_up) begin
            w_up_nxt = 8'd0;
          end else if (w_tick) begin
            w_up_nxt = (r_up == 8'd255) ? 8'd255 : r_up + 8'd1;
            w_y_nxt  = (is_in_middle || (r_y == Y_TOP_V)) ? r_y : r_y - 10'd1;
            w_x_nxt  = w_x_step;
          end else begin
            w_up_nxt = r_up;
          end
        end
        ST_DOWN: begin
          w_up_nxt = 8'd0;
          if (w_tick) begin
            w_y_nxt = (r_y >= Y_FLOOR_V) ? Y_FLOOR_V : r_y + 10'd1;
            w_x_nxt = w_x_step;
          end else begin
            w_y_nxt = r_y;
          end
        end
        ST_DONE: begin
          w_x_nxt = r_x;
        end
        default: begin
          w_x_nxt = r_x;
        end
      endcase
    end else begin
      w_x_nxt = r_x;
    end
  end

  // A malformed state vector freezes everything, synchronizers included.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_x     <= X_START_V;
      r_y     <= Y_START_V;
      r_up    <= 8'd0;
      r_edge  <= 2'b00;
      r_btn_l <= 2'b00;
      r_btn_r <= 2'b00;
    end else if (w_valid) begin
      r_x     <= w_x_nxt;
      r_y     <= w_y_nxt;
      r_up    <= w_up_nxt;
      r_edge  <= {q_Up, q_Down};
      r_btn_l <= {r_btn_l[0], BtnL};
      r_btn_r <= {r_btn_r[0], BtnR};
    end
  end

  assign object_x  = r_x;
  assign object_y  = r_y;
  assign up_count  = r_up;
  assign move_tick = w_tick;

endmodule

// File: tb/tb_doodle_motion.sv
// Directed bench for doodle_motion with a 4-cycle motion step.
module tb_doodle_motion;

  localparam int unsigned TD = 4;

  logic       Clk = 1'b0;
  logic       Reset = 1'b0;
  logic       q_I = 1'b1, q_Up = 1'b0, q_Down = 1'b0, q_Done = 1'b0;
  logic       is_in_middle = 1'b0;
  logic       BtnL = 1'b0, BtnR = 1'b0;
  logic [9:0] object_x, object_y;
  logic [7:0] up_count;
  logic       move_tick;

  int n_pass  = 0;
  int n_total = 0;
  int n_seen  = 0;

  doodle_motion #(.TICK_DIV(TD)) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .q_I         (q_I),
    .q_Up        (q_Up),
    .q_Down      (q_Down),
    .q_Done      (q_Done),
    .is_in_middle(is_in_middle),
    .BtnL        (BtnL),
    .BtnR        (BtnR),
    .object_x    (object_x),
    .object_y    (object_y),
    .up_count    (up_count),
    .move_tick   (move_tick)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic set_state(input logic [3:0] s);
    {q_I, q_Up, q_Down, q_Done} = s;
  endtask

  // Waits for n move_tick pulses (sampled at negedges) within a cycle budget.
  task automatic wait_ticks(input int n, input string tag);
    int seen = 0;
    int cyc = 0;
    while (seen < n && cyc < n * TD + 8) begin
      @(negedge Clk);
      cyc++;
      if (move_tick) seen++;
    end
    check(tag, seen, n);
  endtask

  task automatic check_pos(input string tag, input int x, input int y, input int up);
    check({tag, "_x"}, int'(object_x), x);
    check({tag, "_y"}, int'(object_y), y);
    check({tag, "_up"}, int'(up_count), up);
  endtask

  // Counts move_tick pulses over n cycles.
  task automatic count_ticks(input int n);
    n_seen = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge Clk);
      if (move_tick) n_seen++;
    end
  endtask

  initial begin
    // Asynchronous reset before any clock edge.
    #1 Reset = 1'b1;
    #2;
    check_pos("rst_async", 459, 455, 0);
    check("rst_tick", int'(move_tick), 0);
    @(negedge Clk);
    Reset = 1'b0;

    count_ticks(10);
    check("idle_ticks", n_seen, 0);
    check_pos("idle", 459, 455, 0);

    // Rise: first tick exactly TD cycles after entering q_Up.
    set_state(4'b0100);
    repeat (3) @(negedge Clk);
    check("up_tick_early", int'(move_tick), 0);
    @(negedge Clk);
    check("up_tick_first", int'(move_tick), 1);
    wait_ticks(7, "up8_ticks");
    @(negedge Clk);
    check_pos("up8", 459, 447, 8);
    is_in_middle = 1'b1;
    wait_ticks(5, "mid5_ticks");
    @(negedge Clk);
    check_pos("mid5", 459, 447, 13);

    // Fall to the floor and saturate.
    is_in_middle = 1'b0;
    set_state(4'b0010);
    @(negedge Clk);
    check("down_first_up", int'(up_count), 0);
    wait_ticks(68, "down68_ticks");
    @(negedge Clk);
    check("down_515", int'(object_y), 515);
    wait_ticks(10, "down10_ticks");
    @(negedge Clk);
    check_pos("down_floor", 459, 520, 0);

    // Down -> Up mid-period: divider restarts, up_count cleared.
    @(negedge Clk);
    set_state(4'b0100);
    @(negedge Clk);
    check("up_entry_cnt", int'(up_count), 0);
    check("up_entry_tick", int'(move_tick), 0);
    @(negedge Clk);
    check("up_restart_old_phase", int'(move_tick), 0);
    repeat (2) @(negedge Clk);
    check("up_restart_tick", int'(move_tick), 1);

    // Right moves wrap past X_MAX to X_MIN and on to 156.
    BtnR = 1'b1;
    wait_ticks(154, "right_ticks");
    @(negedge Clk);
    check_pos("right_wrap", 156, 365, 155);
    BtnR = 1'b0;
    BtnL = 1'b1;
    wait_ticks(1, "left1_ticks");
    @(negedge Clk);
    check("left_154", int'(object_x), 154);
    wait_ticks(1, "left2_ticks");
    @(negedge Clk);
    check("left_wrap_764", int'(object_x), 764);
    BtnR = 1'b1;
    wait_ticks(2, "both_ticks");
    @(negedge Clk);
    check_pos("both_hold", 764, 361, 159);

    // up_count saturation and the top limit.
    BtnL = 1'b0;
    BtnR = 1'b0;
    wait_ticks(96, "sat_ticks");
    @(negedge Clk);
    check_pos("up_255", 764, 265, 255);
    wait_ticks(2, "sat2_ticks");
    @(negedge Clk);
    check_pos("up_sat", 764, 263, 255);
    wait_ticks(230, "top_ticks");
    @(negedge Clk);
    check("y_top", int'(object_y), 35);

    // Back to idle, short rise, then Done freezes everything.
    set_state(4'b1000);
    @(negedge Clk);
    check_pos("reinit", 459, 455, 0);
    set_state(4'b0100);
    wait_ticks(3, "pre_done_ticks");
    @(negedge Clk);
    check_pos("pre_done", 459, 452, 3);
    set_state(4'b0001);
    count_ticks(50);
    check("done_ticks", n_seen, 0);
    check_pos("done_frozen", 459, 452, 3);
    set_state(4'b0100);
    @(negedge Clk);
    check("done_to_up_clear", int'(up_count), 0);
    set_state(4'b1000);
    @(negedge Clk);
    check_pos("ack_idle", 459, 455, 0);

    // Reset mid-jump takes effect without a clock edge.
    set_state(4'b0100);
    wait_ticks(20, "up20_ticks");
    @(negedge Clk);
    check_pos("up20", 459, 435, 20);
    #2 Reset = 1'b1;
    #1;
    check_pos("rst_mid", 459, 455, 0);
    check("rst_mid_tick", int'(move_tick), 0);
    @(negedge Clk);
    Reset = 1'b0;
    repeat (3) @(negedge Clk);
    check("post_rst_early", int'(move_tick), 0);
    @(negedge Clk);
    check("post_rst_tick", int'(move_tick), 1);
    @(negedge Clk);
    check_pos("post_rst_step", 459, 454, 1);

    // Malformed state vectors hold all registers.
    set_state(4'b0101);
    BtnR = 1'b1;
    count_ticks(20);
    check("bad2_ticks", n_seen, 0);
    check_pos("bad2_hold", 459, 454, 1);
    set_state(4'b0000);
    count_ticks(10);
    check("bad0_ticks", n_seen, 0);
    check_pos("bad0_hold", 459, 454, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
